// File: rtl/phase_deadtime_guard.sv
// Per-phase break-before-make guard between the driver's half-bridge requests and the gate pins.
// Registered outputs: 1-cycle request-to-gate latency, DEAD_CYCLES all-off gap before any re-drive.
module phase_deadtime_guard #(
   parameter int DEAD_CYCLES = 50,
   parameter int CNT_W       = 10
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       fault_in,
   input  logic [5:0] phase_req,
   input  logic       clear_st,
   output logic [5:0] gate_out,
   output logic [2:0] dead_active,
   output logic       shoot_through
);

   typedef enum logic [1:0] {IDLE, DRIVE_H, DRIVE_L, DEAD} state_t;

   // Decoded requests reuse the {H,L} encoding; 11 never survives decode.
   localparam logic [1:0] REQ_OFF = 2'b00;
   localparam logic [1:0] REQ_H   = 2'b10;
   localparam logic [1:0] REQ_L   = 2'b01;
   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

   state_t           state     [3];
   state_t           state_nxt [3];
   logic [CNT_W-1:0] cnt       [3];
   logic [CNT_W-1:0] cnt_nxt   [3];
   logic [1:0]       req       [3];
   logic [2:0]       illegal;
   logic             gates_off;
   logic [5:0]       gate_nxt;
   logic [2:0]       dead_nxt;
   logic             st_nxt;

   assign gates_off = ~enable | fault_in;

   // Index 0 is phase A, which sits in the top bits of the request bus.
   always_comb begin
      illegal = '0;
      for (int p = 0; p < 3; p++) begin
         illegal[p] = phase_req[5-2*p] & phase_req[4-2*p];
         if (gates_off || illegal[p])
            req[p] = REQ_OFF;
         else
            req[p] = {phase_req[5-2*p], phase_req[4-2*p]};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int p = 0; p < 3; p++) begin
            state[p] <= IDLE;
            cnt[p]   <= '0;
         end
         gate_out      <= '0;
         dead_active   <= '0;
         shoot_through <= 1'b0;
      end else begin
         for (int p = 0; p < 3; p++) begin
            state[p] <= state_nxt[p];
            cnt[p]   <= cnt_nxt[p];
         end
         gate_out      <= gate_nxt;
         dead_active   <= dead_nxt;
         shoot_through <= st_nxt;
      end
   end

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         state_nxt[p] = state[p];
         cnt_nxt[p]   = cnt[p];
         case (state[p])
            IDLE: begin
               if (req[p] == REQ_H)      state_nxt[p] = DRIVE_H;
               else if (req[p] == REQ_L) state_nxt[p] = DRIVE_L;
            end
            DRIVE_H: begin
               if (req[p] != REQ_H) begin
                  state_nxt[p] = DEAD;
                  cnt_nxt[p]   = DEAD_LOAD;
               end
            end
            DRIVE_L: begin
               if (req[p] != REQ_L) begin
                  state_nxt[p] = DEAD;
                  cnt_nxt[p]   = DEAD_LOAD;
               end
            end
            DEAD: begin
               // The count runs to completion regardless of request changes.
               if (cnt[p] == '0) begin
                  if (req[p] == REQ_H)      state_nxt[p] = DRIVE_H;
                  else if (req[p] == REQ_L) state_nxt[p] = DRIVE_L;
                  else                      state_nxt[p] = IDLE;
               end else begin
                  cnt_nxt[p] = cnt[p] - CNT_W'(1);
               end
            end
            default: state_nxt[p] = IDLE;
         endcase
      end
   end

   always_comb begin
      gate_nxt = '0;
      dead_nxt = '0;
      for (int p = 0; p < 3; p++) begin
         gate_nxt[5-2*p] = (state_nxt[p] == DRIVE_H);
         gate_nxt[4-2*p] = (state_nxt[p] == DRIVE_L);
         dead_nxt[2-p]   = (state_nxt[p] == DEAD);
      end
      // A fresh illegal request beats a simultaneous clear.
      if (|illegal)
         st_nxt = 1'b1;
      else if (clear_st)
         st_nxt = 1'b0;
      else
         st_nxt = shoot_through;
   end

endmodule
